// File: rtl/writeback_stage.sv
// Writeback stage: registers MEM results and drives the register-file write port and decode bypass.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
    parameter logic [4:0]  RETURN_ADDRESS = 5'd31,
    parameter logic [31:0] LINK_OFFSET    = 32'd8
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        memValid,
    output logic        memReady,
    input  logic        stall,
    input  logic [31:0] insnPc,
    input  logic [31:0] aluResult,
    input  logic [31:0] loadData,
    input  logic        regWrite,
    input  logic [1:0]  dstSel,
    input  logic [1:0]  srcSel,
    input  logic [1:0]  loadSize,
    input  logic        loadUnsigned,
    input  logic [4:0]  rtIn,
    input  logic [4:0]  rdIn,
    output logic        rfWriteEnable,
    output logic [4:0]  rfWriteAddr,
    output logic [31:0] rfWriteData,
    output logic        bypassValid,
    output logic        misalignErr,
    output logic [31:0] retireCount
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        reg_write;
        logic [1:0]  dst_sel;
        logic [1:0]  src_sel;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } stage_t;

    stage_t stage_q;

    logic        accept;
    logic        in_misaligned;
    logic        misaligned;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        dst_none;

    // A load is misaligned when a half uses an odd offset or a word any nonzero offset.
    function automatic logic is_misaligned(
        input logic [1:0] src,
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        if (src == 2'b01) begin
            if (size == 2'b01) bad = off[0];
            else if (size != 2'b00) bad = (off != 2'b00);
        end
        return bad;
    endfunction

    assign accept        = memValid & ~stall;
    assign in_misaligned = is_misaligned(srcSel, loadSize, aluResult[1:0]);
    assign memReady      = resetN & ~stall;

    // Stage register: capture on accept, bubble when idle, hold while stalled.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stage_q <= '0;
        end else if (!stall) begin
            stage_q.valid <= memValid;
            if (memValid) begin
                stage_q.pc            <= insnPc;
                stage_q.alu           <= aluResult;
                stage_q.ld            <= loadData;
                stage_q.reg_write     <= regWrite;
                stage_q.dst_sel       <= dstSel;
                stage_q.src_sel       <= srcSel;
                stage_q.load_size     <= loadSize;
                stage_q.load_unsigned <= loadUnsigned;
                stage_q.rt            <= rtIn;
                stage_q.rd            <= rdIn;
            end
        end
    end

    // Sticky error flag, raised as soon as a misaligned load enters the stage.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            misalignErr <= 1'b0;
        end else if (accept && in_misaligned) begin
            misalignErr <= 1'b1;
        end
    end

    // Big-endian lane extraction and extension of the loaded word.
    always_comb begin
        byte_val = stage_q.ld[31:24];
        unique case (stage_q.alu[1:0])
            2'd0: byte_val = stage_q.ld[31:24];
            2'd1: byte_val = stage_q.ld[23:16];
            2'd2: byte_val = stage_q.ld[15:8];
            2'd3: byte_val = stage_q.ld[7:0];
        endcase
        half_val = stage_q.alu[1] ? stage_q.ld[15:0] : stage_q.ld[31:16];
        load_val = stage_q.ld;
        unique case (stage_q.load_size)
            2'b00: load_val = {{24{~stage_q.load_unsigned & byte_val[7]}}, byte_val};
            2'b01: load_val = {{16{~stage_q.load_unsigned & half_val[15]}}, half_val};
            default: load_val = stage_q.ld;
        endcase
    end

    // Source and destination selection for the write port.
    always_comb begin
        data = '0;
        unique case (stage_q.src_sel)
            2'b00: data = stage_q.alu;
            2'b01: data = load_val;
            2'b10: data = stage_q.pc + LINK_OFFSET;
            2'b11: data = '0;
        endcase
        addr     = '0;
        dst_none = 1'b0;
        unique case (stage_q.dst_sel)
            2'b00: addr = stage_q.rt;
            2'b01: addr = stage_q.rd;
            2'b10: addr = RETURN_ADDRESS;
            2'b11: dst_none = 1'b1;
        endcase
    end

    assign misaligned = is_misaligned(stage_q.src_sel, stage_q.load_size, stage_q.alu[1:0]);

    assign rfWriteEnable = stage_q.valid & stage_q.reg_write & ~dst_none
                         & (addr != 5'd0) & ~misaligned & ~stall;
    assign bypassValid   = rfWriteEnable;
    assign rfWriteAddr   = stage_q.valid ? addr : 5'd0;
    assign rfWriteData   = stage_q.valid ? data : 32'd0;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Count every stage cycle that retires an instruction, whether or not it writes.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            retire_q <= '0;
        end else if (stage_q.valid && !stall) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retireCount = retire_q;
`else
    assign retireCount = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed table, stall/reset sequences,
// and randomized traffic against a behavioural model.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        resetN;
    logic        memValid;
    logic        memReady;
    logic        stall;
    logic [31:0] insnPc;
    logic [31:0] aluResult;
    logic [31:0] loadData;
    logic        regWrite;
    logic [1:0]  dstSel;
    logic [1:0]  srcSel;
    logic [1:0]  loadSize;
    logic        loadUnsigned;
    logic [4:0]  rtIn;
    logic [4:0]  rdIn;
    logic        rfWriteEnable;
    logic [4:0]  rfWriteAddr;
    logic [31:0] rfWriteData;
    logic        bypassValid;
    logic        misalignErr;
    logic [31:0] retireCount;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    writeback_stage dut (
        .clock(clock), .resetN(resetN), .memValid(memValid), .memReady(memReady),
        .stall(stall), .insnPc(insnPc), .aluResult(aluResult), .loadData(loadData),
        .regWrite(regWrite), .dstSel(dstSel), .srcSel(srcSel), .loadSize(loadSize),
        .loadUnsigned(loadUnsigned), .rtIn(rtIn), .rdIn(rdIn),
        .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr),
        .rfWriteData(rfWriteData), .bypassValid(bypassValid),
        .misalignErr(misalignErr), .retireCount(retireCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mv;
        logic        st;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        rw;
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        in_t         x;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        mis;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    logic        m_valid;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_sticky;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [1:0] dst, input logic [1:0] src,
                               input logic [1:0] sz, input logic uns,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] ld, input logic rw);
        in_t x;
        x.mv = 1'b1; x.st = 1'b0; x.pc = pc; x.alu = alu; x.ld = ld;
        x.rw = rw; x.dst = dst; x.src = src; x.sz = sz; x.uns = uns;
        x.rt = rt; x.rd = rd;
        return x;
    endfunction

    function automatic in_t idle(input logic st);
        in_t x;
        x = mk(2'b11, 2'b11, 2'b00, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        x.mv = 1'b0;
        x.st = st;
        return x;
    endfunction

    task automatic drive(input in_t x);
        memValid = x.mv; stall = x.st; insnPc = x.pc; aluResult = x.alu;
        loadData = x.ld; regWrite = x.rw; dstSel = x.dst; srcSel = x.src;
        loadSize = x.sz; loadUnsigned = x.uns; rtIn = x.rt; rdIn = x.rd;
    endtask

    // Reference: what the register file should see for an instruction.
    task automatic model_eval(input in_t x, output logic we, output logic [4:0] a,
                              output logic [31:0] d, output logic mis);
        int off;
        int bytes[5];
        int v;
        off = int'(x.alu % 4);
        for (int i = 0; i < 4; i++) bytes[i] = int'((x.ld >> (24 - 8 * i)) & 32'hFF);
        bytes[4] = 0;
        mis = (x.src == 2'b01) &&
              ((x.sz == 2'b01 && off % 2 == 1) || (x.sz >= 2'b10 && off != 0));
        case (x.dst)
            2'b00: a = x.rt;
            2'b01: a = x.rd;
            2'b10: a = 5'd31;
            default: a = 5'd0;
        endcase
        case (x.src)
            2'b00: d = x.alu;
            2'b10: d = x.pc + 32'd8;
            2'b11: d = 32'd0;
            default: begin
                if (x.sz == 2'b00) begin
                    v = bytes[off];
                    if (!x.uns && v >= 128) v = v - 256;
                    d = 32'(v);
                end else if (x.sz == 2'b01) begin
                    v = bytes[off] * 256 + bytes[off + 1];
                    if (!x.uns && v >= 32768) v = v - 65536;
                    d = 32'(v);
                end else begin
                    d = x.ld;
                end
            end
        endcase
        we = x.rw && x.dst != 2'b11 && a != 5'd0 && !mis;
    endtask

    // Advance the model across one rising edge with the inputs applied in that cycle.
    task automatic model_edge(input in_t x);
        logic mis;
        if (m_valid && !x.st) m_cnt = m_cnt + 32'd1;
        if (!x.st) begin
            if (x.mv) begin
                model_eval(x, m_we, m_addr, m_data, mis);
                if (mis) m_sticky = 1'b1;
            end
            m_valid = x.mv;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        m_sticky = 1'b0; m_cnt = '0;
    endtask

    vec_t vt[$];

    initial begin
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_mis;
        logic        sticky;
        in_t         x;
        logic [31:0] ldp;

        ldp = 32'h80FF_7F01;
        resetN = 1'b0;
        drive(idle(1'b0));
        model_reset();
        #12;
        chk("reset_we", {31'd0, rfWriteEnable}, 32'd0);
        chk("reset_addr", {27'd0, rfWriteAddr}, 32'd0);
        chk("reset_data", rfWriteData, 32'd0);
        chk("reset_mis", {31'd0, misalignErr}, 32'd0);
        chk("reset_cnt", retireCount, 32'd0);
        chk("reset_ready", {31'd0, memReady}, 32'd0);
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;

        // stall: 3 held cycles, one strobe after release
        drive(mk(2'b01, 2'b00, 2'b10, 1'b0, 5'd2, 5'd9, 32'd0, 32'hCAFE_0001, 32'd0, 1'b1));
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            x = mk(2'b01, 2'b00, 2'b10, 1'b0, 5'd2, 5'd4, 32'd0, 32'h1111_1111, 32'd0, 1'b1);
            x.st = 1'b1;
            drive(x);
            #1;
            chk("stall_we", {31'd0, rfWriteEnable}, 32'd0);
            chk("stall_ready", {31'd0, memReady}, 32'd0);
            @(posedge clock); #1;
        end
        drive(idle(1'b0));
        #1;
        chk("release_we", {31'd0, rfWriteEnable}, 32'd1);
        chk("release_addr", {27'd0, rfWriteAddr}, 32'd9);
        chk("release_data", rfWriteData, 32'hCAFE_0001);
        chk("release_cnt", retireCount, 32'd0);
        @(posedge clock); #1;
        #1;
        chk("after_release_we", {31'd0, rfWriteEnable}, 32'd0);
        chk("after_release_cnt", retireCount, CNT_EN ? 32'd1 : 32'd0);

        // directed table
        vt.push_back('{mk(2'b01, 2'b00, 2'b10, 1'b0, 5'd0, 5'd5, 32'd0, 32'h1234_5678, 32'd0, 1'b1), 1'b1, 5'd5, 32'h1234_5678, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b00, 1'b0, 5'd3, 5'd0, 32'd0, 32'h100, ldp, 1'b1), 1'b1, 5'd3, 32'hFFFF_FF80, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b00, 1'b1, 5'd3, 5'd0, 32'd0, 32'h101, ldp, 1'b1), 1'b1, 5'd3, 32'h0000_00FF, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b00, 1'b0, 5'd3, 5'd0, 32'd0, 32'h103, ldp, 1'b1), 1'b1, 5'd3, 32'h0000_0001, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b01, 1'b0, 5'd6, 5'd0, 32'd0, 32'h102, ldp, 1'b1), 1'b1, 5'd6, 32'h0000_7F01, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b01, 1'b0, 5'd6, 5'd0, 32'd0, 32'h100, ldp, 1'b1), 1'b1, 5'd6, 32'hFFFF_80FF, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b01, 1'b1, 5'd6, 5'd0, 32'd0, 32'h100, ldp, 1'b1), 1'b1, 5'd6, 32'h0000_80FF, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b10, 1'b0, 5'd7, 5'd0, 32'd0, 32'h104, ldp, 1'b1), 1'b1, 5'd7, 32'h80FF_7F01, 1'b0});
        vt.push_back('{mk(2'b10, 2'b10, 2'b00, 1'b0, 5'd1, 5'd2, 32'h0040_0010, 32'd0, 32'd0, 1'b1), 1'b1, 5'd31, 32'h0040_0018, 1'b0});
        vt.push_back('{mk(2'b01, 2'b11, 2'b00, 1'b0, 5'd1, 5'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1), 1'b1, 5'd7, 32'd0, 1'b0});
        vt.push_back('{mk(2'b00, 2'b00, 2'b00, 1'b0, 5'd0, 5'd8, 32'd0, 32'h55, 32'd0, 1'b1), 1'b0, 5'd0, 32'd0, 1'b0});
        vt.push_back('{mk(2'b11, 2'b00, 2'b00, 1'b0, 5'd4, 5'd8, 32'd0, 32'h55, 32'd0, 1'b1), 1'b0, 5'd0, 32'd0, 1'b0});
        vt.push_back('{mk(2'b01, 2'b00, 2'b00, 1'b0, 5'd4, 5'd8, 32'd0, 32'h55, 32'd0, 1'b0), 1'b0, 5'd0, 32'd0, 1'b0});
        vt.push_back('{mk(2'b00, 2'b01, 2'b01, 1'b0, 5'd9, 5'd0, 32'd0, 32'h101, ldp, 1'b1), 1'b0, 5'd0, 32'd0, 1'b1});
        vt.push_back('{mk(2'b01, 2'b00, 2'b00, 1'b0, 5'd0, 5'd12, 32'd0, 32'h77, 32'd0, 1'b1), 1'b1, 5'd12, 32'h77, 1'b1});
        vt.push_back('{mk(2'b00, 2'b01, 2'b10, 1'b0, 5'd9, 5'd0, 32'd0, 32'h102, ldp, 1'b1), 1'b0, 5'd0, 32'd0, 1'b1});

        foreach (vt[i]) begin
            drive(vt[i].x);
            @(posedge clock); #1;
            drive(idle(1'b0));
            #1;
            chk($sformatf("tbl%0d_we", i), {31'd0, rfWriteEnable}, {31'd0, vt[i].we});
            chk($sformatf("tbl%0d_byp", i), {31'd0, bypassValid}, {31'd0, vt[i].we});
            chk($sformatf("tbl%0d_mis", i), {31'd0, misalignErr}, {31'd0, vt[i].mis});
            if (vt[i].we) begin
                chk($sformatf("tbl%0d_addr", i), {27'd0, rfWriteAddr}, {27'd0, vt[i].a});
                chk($sformatf("tbl%0d_data", i), rfWriteData, vt[i].d);
            end
            @(posedge clock); #1;
        end
        chk("tbl_cnt", retireCount, CNT_EN ? 32'(1 + vt.size()) : 32'd0);

        // reset mid-stream with a pending write
        drive(mk(2'b01, 2'b00, 2'b00, 1'b0, 5'd0, 5'd13, 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b1));
        @(posedge clock); #1;
        drive(idle(1'b0));
        #1;
        chk("pre_reset_we", {31'd0, rfWriteEnable}, 32'd1);
        resetN = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, rfWriteEnable}, 32'd0);
        chk("async_rst_addr", {27'd0, rfWriteAddr}, 32'd0);
        chk("async_rst_data", rfWriteData, 32'd0);
        chk("async_rst_byp", {31'd0, bypassValid}, 32'd0);
        chk("async_rst_mis", {31'd0, misalignErr}, 32'd0);
        chk("async_rst_cnt", retireCount, 32'd0);
        model_reset();
        @(posedge clock); #1;
        resetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("post_rst_we", {31'd0, rfWriteEnable}, 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            x.mv  = ($urandom_range(0, 3) != 0);
            x.st  = ($urandom_range(0, 3) == 0);
            x.pc  = $urandom;
            x.alu = $urandom;
            x.ld  = $urandom;
            x.rw  = ($urandom_range(0, 7) != 0);
            x.dst = 2'($urandom_range(0, 3));
            x.src = 2'($urandom_range(0, 3));
            x.sz  = 2'($urandom_range(0, 2));
            x.uns = 1'($urandom_range(0, 1));
            x.rt  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            x.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if (i < 60) x.src = 2'b00;
            drive(x);
            #1;
            e_we = m_valid && m_we && !x.st;
            chk("rnd_we", {31'd0, rfWriteEnable}, {31'd0, e_we});
            chk("rnd_byp", {31'd0, bypassValid}, {31'd0, e_we});
            chk("rnd_ready", {31'd0, memReady}, {31'd0, !x.st});
            chk("rnd_mis", {31'd0, misalignErr}, {31'd0, m_sticky});
            chk("rnd_cnt", retireCount, CNT_EN ? m_cnt : 32'd0);
            if (m_valid && m_we) begin
                chk("rnd_addr", {27'd0, rfWriteAddr}, {27'd0, m_addr});
                chk("rnd_data", rfWriteData, m_data);
            end
            @(posedge clock);
            model_edge(x);
            #1;
        end
        sticky = m_sticky;
        e_a = '0; e_d = '0; e_mis = sticky;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
